// File: rtl/led_pkg.sv
// Shared types and constants for the RGB LED fade sequencer.
package led_pkg;

  localparam int DUTY_W_DEFAULT = 8;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } fade_state_t;

  // Index of the lowest set bit of a 3-bit channel mask (red when empty).
  function automatic logic [1:0] lowest_set(input logic [2:0] mask);
    logic [1:0] idx;
    idx = CH_R;
    for (int i = 2; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the system clock down to one duty-step tick every STEP_DIV cycles.
module step_prescaler #(
  parameter int STEP_DIV = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic [CNT_W-1:0] count;

  assign tick = run && (count == CNT_W'(STEP_DIV - 1));

  // Count only while running; wrap on the tick cycle, restart from zero on clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_fade_sequencer.sv
// Sequences the RGB LED through per-channel fade cycles: ramp up, hold high,
// ramp down, hold low, then rotate to the next channel enabled in the mask.
module led_fade_sequencer
  import led_pkg::*;
#(
  parameter int STEP_DIV   = 500000,
  parameter int HOLD_STEPS = 64,
  parameter int DUTY_W     = DUTY_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [2:0]        channel_mask,
  output logic [DUTY_W-1:0] duty_r,
  output logic [DUTY_W-1:0] duty_g,
  output logic [DUTY_W-1:0] duty_b,
  output logic [1:0]        active_ch,
  output logic              busy,
  output logic              cycle_done
);

  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  fade_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [1:0]        ch_q, ch_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_d;
  logic              clear;
  logic              tick;
  logic [2:0]        nxt;

  // Priority rotate: next set bit above cur, else wrap to the lowest set bit.
  // Bit 2 of the result flags that a wrap happened.
  function automatic logic [2:0] pick_next(input logic [1:0] cur, input logic [2:0] mask);
    logic [2:0] res;
    res = {1'b1, lowest_set(mask)};
    for (int i = 2; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur))) res = {1'b0, 2'(i)};
    end
    return res;
  endfunction

  assign busy      = (state_q != IDLE);
  assign active_ch = ch_q;

  step_prescaler #(
    .STEP_DIV(STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .run  (busy),
    .tick (tick)
  );

  // Next-state logic: every fade step advances only on a prescaler tick.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    ch_d    = ch_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    nxt     = '0;

    case (state_q)
      IDLE: begin
        duty_d = '0;
        ch_d   = CH_R;
        hold_d = '0;
        if (enable && (channel_mask != 3'b000)) begin
          state_d = RAMP_UP;
          ch_d    = lowest_set(channel_mask);
          clear   = 1'b1;
        end
      end

      RAMP_UP: begin
        if (tick) begin
          if (duty_q == DUTY_MAX) begin
            state_d = HOLD_HI;
            hold_d  = '0;
          end else begin
            duty_d = duty_q + DUTY_W'(1);
          end
        end
      end

      HOLD_HI: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = RAMP_DOWN;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      RAMP_DOWN: begin
        if (tick) begin
          if (duty_q == '0) begin
            state_d = HOLD_LO;
            hold_d  = '0;
          end else begin
            duty_d = duty_q - DUTY_W'(1);
          end
        end
      end

      HOLD_LO: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            duty_d = '0;
            hold_d = '0;
            if (channel_mask == 3'b000) begin
              state_d = IDLE;
              ch_d    = CH_R;
            end else begin
              nxt     = pick_next(ch_q, channel_mask);
              state_d = RAMP_UP;
              ch_d    = nxt[1:0];
              done_d  = nxt[2];
            end
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        duty_d  = '0;
        ch_d    = CH_R;
        hold_d  = '0;
      end
    endcase

    if ((state_q != IDLE) && !enable) begin
      state_d = IDLE;
      duty_d  = '0;
      ch_d    = CH_R;
      hold_d  = '0;
      done_d  = 1'b0;
      clear   = 1'b0;
    end
  end

  // State and registered outputs; only the active channel carries the duty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      ch_q       <= CH_R;
      hold_q     <= '0;
      duty_r     <= '0;
      duty_g     <= '0;
      duty_b     <= '0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      ch_q       <= ch_d;
      hold_q     <= hold_d;
      duty_r     <= (ch_d == CH_R) ? duty_d : '0;
      duty_g     <= (ch_d == CH_G) ? duty_d : '0;
      duty_b     <= (ch_d == CH_B) ? duty_d : '0;
      cycle_done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Scoreboard bench for led_fade_sequencer: a time-based reference model predicts
// every change of the outputs; a monitor pops a prediction whenever the DUT changes.
module tb_led_fade_sequencer;

  localparam int SD           = 4;
  localparam int HS           = 2;
  localparam int DMAX         = 255;
  localparam int PERIOD_STEPS = 2*DMAX + 2 + 2*HS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] channel_mask;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [1:0] active_ch;
  logic       busy;
  logic       cycle_done;

  typedef struct {
    int         cyc;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] ch;
    logic       busy;
    logic       done;
  } rec_t;

  rec_t exp_q[$];
  rec_t last_exp;
  bit   have_last = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   m_run = 1'b0;
  int   m_ch = 0;
  int   m_t0 = 0;
  bit   mon_first = 1'b1;
  logic [27:0] mon_prev;
  logic [27:0] mon_cur;

  led_fade_sequencer #(
    .STEP_DIV  (SD),
    .HOLD_STEPS(HS),
    .DUTY_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .channel_mask(channel_mask),
    .duty_r      (duty_r),
    .duty_g      (duty_g),
    .duty_b      (duty_b),
    .active_ch   (active_ch),
    .busy        (busy),
    .cycle_done  (cycle_done)
  );

  // 10-unit system clock.
  always #5 clk = ~clk;

  // Duty of the active channel s steps after that channel started its fade.
  function automatic int dutyAt(input int s);
    if (s <= DMAX)                return s;
    else if (s <= DMAX + 1 + HS)  return DMAX;
    else if (s <= 2*DMAX + 1 + HS) return DMAX - (s - DMAX - 1 - HS);
    else                          return 0;
  endfunction

  function automatic bit sameOut(input rec_t x, input rec_t y);
    return (x.r === y.r) && (x.g === y.g) && (x.b === y.b) &&
           (x.ch === y.ch) && (x.busy === y.busy) && (x.done === y.done);
  endfunction

  // Predict the outputs after the edge just taken and queue them if they changed.
  task automatic modelEdge();
    rec_t e;
    int   s;
    int   d;
    int   c;
    bit   found;
    e.cyc = cyc; e.r = 8'd0; e.g = 8'd0; e.b = 8'd0;
    e.ch = 2'd0; e.busy = 1'b0; e.done = 1'b0;
    if (rst_n !== 1'b1) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (enable && (channel_mask != 3'b000)) begin
        m_run = 1'b1;
        m_t0  = cyc;
        for (int i = 2; i >= 0; i--) if (channel_mask[i]) m_ch = i;
      end
    end else if (!enable) begin
      m_run = 1'b0;
    end else if (cyc - m_t0 == PERIOD_STEPS * SD) begin
      if (channel_mask == 3'b000) begin
        m_run = 1'b0;
      end else begin
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
          c = (m_ch + k) % 3;
          if (!found && channel_mask[c]) begin
            found  = 1'b1;
            e.done = (m_ch + k >= 3);
            m_ch   = c;
          end
        end
        m_t0 = cyc;
      end
    end
    if (m_run) begin
      s      = (cyc - m_t0) / SD;
      d      = dutyAt(s);
      e.busy = 1'b1;
      e.ch   = 2'(m_ch);
      case (m_ch)
        0:       e.r = 8'(d);
        1:       e.g = 8'(d);
        default: e.b = 8'(d);
      endcase
    end
    if (!have_last || !sameOut(e, last_exp)) begin
      exp_q.push_back(e);
      last_exp  = e;
      have_last = 1'b1;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    #1 modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input bit en, input logic [2:0] m, input bit rst, input int n);
    rst_n        = ~rst;
    enable       = en;
    channel_mask = m;
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic checkOutput(input string name, input rec_t e, input rec_t a);
    checks++;
    if ((a.cyc != e.cyc) || !sameOut(a, e)) begin
      errors++;
      $display("[TB] FAIL %s: got cyc=%0d r=%0d g=%0d b=%0d ch=%0d busy=%0b done=%0b, expected cyc=%0d r=%0d g=%0d b=%0d ch=%0d busy=%0b done=%0b",
               name, a.cyc, a.r, a.g, a.b, a.ch, a.busy, a.done,
               e.cyc, e.r, e.g, e.b, e.ch, e.busy, e.done);
    end
  endtask

  // Monitor: every observed output change must match the next predicted change.
  initial begin : monitor
    rec_t a;
    rec_t e;
    forever begin
      @(negedge clk);
      mon_cur = {duty_r, duty_g, duty_b, active_ch, busy, cycle_done};
      if (mon_first || (mon_cur !== mon_prev)) begin
        mon_first = 1'b0;
        a.cyc = cyc; a.r = duty_r; a.g = duty_g; a.b = duty_b;
        a.ch = active_ch; a.busy = busy; a.done = cycle_done;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change: got cyc=%0d r=%0d g=%0d b=%0d ch=%0d busy=%0b done=%0b, expected no change",
                   a.cyc, a.r, a.g, a.b, a.ch, a.busy, a.done);
        end else begin
          e = exp_q.pop_front();
          checkOutput("output_change", e, a);
        end
      end
      mon_prev = mon_cur;
    end
  end

  // Stimulus: directed scenarios followed by randomized segments.
  initial begin : driver
    rec_t e;
    applyStimulus(1'b0, 3'b000, 1'b1, 3);

    $display("[TB] single red channel");
    applyStimulus(1'b1, 3'b001, 1'b0, 4200);
    applyStimulus(1'b0, 3'b001, 1'b0, 2);

    $display("[TB] red and blue");
    applyStimulus(1'b1, 3'b101, 1'b0, 4200);
    applyStimulus(1'b0, 3'b101, 1'b0, 2);

    $display("[TB] enable dropped during green ramp, then re-enabled");
    applyStimulus(1'b1, 3'b011, 1'b0, 1 + PERIOD_STEPS*SD + 100*SD + $urandom_range(0, 3));
    applyStimulus(1'b0, 3'b011, 1'b0, 5);
    applyStimulus(1'b1, 3'b011, 1'b0, 2100);
    applyStimulus(1'b0, 3'b011, 1'b0, 2);

    $display("[TB] mask changed while red ramps");
    applyStimulus(1'b1, 3'b011, 1'b0, $urandom_range(2, 1000));
    applyStimulus(1'b1, 3'b100, 1'b0, 2*PERIOD_STEPS*SD + 200);
    applyStimulus(1'b0, 3'b100, 1'b0, 2);

    $display("[TB] reset during hold high");
    applyStimulus(1'b1, 3'b001, 1'b0, 1 + 256*SD + $urandom_range(0, 6));
    applyStimulus(1'b1, 3'b001, 1'b1, 1);
    applyStimulus(1'b1, 3'b001, 1'b0, 50);

    $display("[TB] empty mask with enable");
    applyStimulus(1'b1, 3'b000, 1'b1, 1);
    applyStimulus(1'b1, 3'b000, 1'b0, 200);

    $display("[TB] randomized segments");
    for (int seg = 0; seg < 10; seg++) begin
      applyStimulus($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)),
                    $urandom_range(0, 15) == 0, $urandom_range(1, 2500));
    end

    applyStimulus(1'b0, 3'b000, 1'b1, 3);
    @(negedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL missing_change: got nothing, expected cyc=%0d r=%0d g=%0d b=%0d ch=%0d busy=%0b done=%0b",
               e.cyc, e.r, e.g, e.b, e.ch, e.busy, e.done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
